// File: rtl/jtopl_slot_sched.sv
// Slot sequencer for the OPL operator ring: prescaled slot counter plus a small
// ordered write queue applied on slot entry. Define JTOPL_SCHED_FIFO2_EN for a 2-deep queue.
module jtopl_slot_sched #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 18,
   parameter int DIV    = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cen,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [4:0]       wr_slot,
   input  logic [WIDTH-1:0] wr_data,
   output logic [4:0]       slot,
   output logic             zero,
   output logic [2:0]       group,
   output logic [1:0]       sub,
   output logic             slot_adv,
   output logic             upd_en,
   output logic [WIDTH-1:0] upd_data,
   output logic             err
);

`ifdef JTOPL_SCHED_FIFO2_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0]    presc_r;
   logic [4:0]       slot_r;
   logic [1:0]       cnt_r;
   logic [4:0]       q_slot_r [DEPTH];
   logic [WIDTH-1:0] q_data_r [DEPTH];
   logic             upd_en_r;
   logic [WIDTH-1:0] upd_data_r;
   logic             err_r;

   logic             adv_s;
   logic [4:0]       next_slot_s;
   logic             ready_s;
   logic             xfer_s;
   logic             bad_s;
   logic             push_s;
   logic             pop_s;
   logic [1:0]       widx_s;

   // Advance strobe, queue handshake and head-match decision
   always_comb begin
      adv_s       = rst_n & cen & (presc_r == PW'(DIV - 1));
      next_slot_s = (slot_r == 5'(STAGES - 1)) ? 5'd0 : slot_r + 5'd1;
      ready_s     = (cnt_r != 2'(DEPTH));
      xfer_s      = wr_valid & ready_s;
      bad_s       = xfer_s & (wr_slot >= 5'(STAGES));
      push_s      = xfer_s & ~bad_s;
      pop_s       = adv_s & (cnt_r != 2'd0) & (q_slot_r[0] == next_slot_s);
      // a pop in the same edge frees the head, so the new entry lands one lower
      widx_s      = pop_s ? (cnt_r - 2'd1) : cnt_r;
   end

   // Prescaler and slot counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= {PW{1'b0}};
         slot_r  <= 5'd0;
      end else begin
         if (cen) begin
            presc_r <= (presc_r == PW'(DIV - 1)) ? {PW{1'b0}} : presc_r + PW'(1);
         end
         if (adv_s) begin
            slot_r <= next_slot_s;
         end
      end
   end

   // Ordered pending-write queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 2'd0;
         for (int i = 0; i < DEPTH; i++) begin
            q_slot_r[i] <= 5'd0;
            q_data_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push_s && !pop_s) begin
            cnt_r <= cnt_r + 2'd1;
         end else if (pop_s && !push_s) begin
            cnt_r <= cnt_r - 2'd1;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (widx_s == 2'(i))) begin
               q_slot_r[i] <= wr_slot;
               q_data_r[i] <= wr_data;
            end else if (pop_s && (i < DEPTH - 1)) begin
               q_slot_r[i] <= q_slot_r[(i + 1) % DEPTH];
               q_data_r[i] <= q_data_r[(i + 1) % DEPTH];
            end
         end
      end
   end

   // Ring update strobe, held data and sticky bad-slot flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_en_r   <= 1'b0;
         upd_data_r <= {WIDTH{1'b0}};
         err_r      <= 1'b0;
      end else begin
         upd_en_r <= pop_s;
         if (pop_s) begin
            upd_data_r <= q_data_r[0];
         end
         if (bad_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign wr_ready = ready_s;
   assign slot     = slot_r;
   assign zero     = (slot_r == 5'd0);
   assign group    = 3'(slot_r / 5'd3);
   assign sub      = 2'(slot_r % 5'd3);
   assign slot_adv = adv_s;
   assign upd_en   = upd_en_r;
   assign upd_data = upd_data_r;
   assign err      = err_r;

endmodule

// File: tb/tb_jtopl_slot_sched.sv
// Bench for jtopl_slot_sched: table of counter vectors, directed queue scenarios and
// randomized traffic against a queue-based reference model.
module tb_jtopl_slot_sched;
   localparam int WIDTH  = 8;
   localparam int STAGES = 18;
   localparam int DIV    = 4;
`ifdef JTOPL_SCHED_FIFO2_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0, wr_valid = 1'b0;
   logic [4:0] wr_slot = 5'd0;
   logic [7:0] wr_data = 8'd0;
   logic wr_ready, zero, slot_adv, upd_en, err;
   logic [4:0] slot;
   logic [2:0] group;
   logic [1:0] sub;
   logic [7:0] upd_data;

   jtopl_slot_sched #(.WIDTH(WIDTH), .STAGES(STAGES), .DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_slot(wr_slot), .wr_data(wr_data), .slot(slot), .zero(zero), .group(group),
      .sub(sub), .slot_adv(slot_adv), .upd_en(upd_en), .upd_data(upd_data), .err(err));

   always #5 clk = ~clk;

   int total = 0, passed = 0, fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else begin
         fails++;
         if (fails <= 50) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: cen count, slot number and a queue of pending writes
   typedef struct { int s; logic [7:0] d; } ent_t;
   ent_t q_m[$];
   int pc_m, slot_m;
   bit err_m, upd_en_m;
   logic [7:0] upd_data_m;

   task automatic model_reset();
      pc_m = 0; slot_m = 0; err_m = 0; upd_en_m = 0; upd_data_m = 8'd0; q_m.delete();
   endtask

   task automatic model_step();
      bit ready, adv;
      int ns;
      ent_t e;
      if (!rst_n) begin model_reset(); return; end
      ready = (q_m.size() < DEPTH);
      adv = cen && (pc_m == DIV - 1);
      ns = (slot_m + 1) % STAGES;
      upd_en_m = 0;
      if (adv && q_m.size() > 0 && q_m[0].s == ns) begin
         upd_en_m = 1; upd_data_m = q_m[0].d; void'(q_m.pop_front());
      end
      if (wr_valid && ready) begin
         if (wr_slot >= STAGES) err_m = 1;
         else begin e.s = wr_slot; e.d = wr_data; q_m.push_back(e); end
      end
      if (cen) pc_m = (pc_m + 1) % DIV;
      if (adv) slot_m = ns;
   endtask

   task automatic compare_all();
      chk("slot", slot, slot_m);
      chk("zero", zero, slot_m == 0);
      chk("group", group, (slot_m / 3) % 8);
      chk("sub", sub, slot_m % 3);
      chk("slot_adv", slot_adv, rst_n && cen && pc_m == DIV - 1);
      chk("wr_ready", wr_ready, q_m.size() < DEPTH);
      chk("upd_en", upd_en, upd_en_m);
      chk("upd_data", upd_data, upd_data_m);
      chk("err", err, err_m);
   endtask

   task automatic drive_mid(input logic c, input logic v, input logic [4:0] s, input logic [7:0] d);
      cen = c; wr_valid = v; wr_slot = s; wr_data = d;
      #4;
      compare_all();
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic cyc(input logic c, input logic v, input logic [4:0] s, input logic [7:0] d);
      drive_mid(c, v, s, d);
      edge_step();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      model_reset();
      drive_mid(1'b1, 1'b0, 5'd0, 8'd0);
      edge_step();
      rst_n = 1'b1;
   endtask

   task automatic run_to_slot(input int target);
      int n = 0;
      while (!(slot_m == target && pc_m == 0) && n < 200) begin
         cyc(1'b1, 1'b0, 5'd0, 8'd0); n++;
      end
      chk("reach_slot_timeout", n < 200, 1);
   endtask

   typedef struct { int k; int sl; int z; int g; int sb; int adv; } vec_t;
   vec_t tbl[10];

   initial begin
      int adv_cnt, ups, first_adv, n;
      bit got;
      tbl[0] = '{0, 0, 1, 0, 0, 0};
      tbl[1] = '{3, 0, 1, 0, 0, 1};
      tbl[2] = '{4, 1, 0, 0, 1, 0};
      tbl[3] = '{11, 2, 0, 0, 2, 1};
      tbl[4] = '{12, 3, 0, 1, 0, 0};
      tbl[5] = '{40, 10, 0, 3, 1, 0};
      tbl[6] = '{67, 16, 0, 5, 1, 1};
      tbl[7] = '{68, 17, 0, 5, 2, 0};
      tbl[8] = '{71, 17, 0, 5, 2, 1};
      tbl[9] = '{72, 0, 1, 0, 0, 0};
      model_reset();

      // counter walk with cen every clk
      do_reset();
      adv_cnt = 0;
      for (int k = 0; k <= 72; k++) begin
         drive_mid(1'b1, 1'b0, 5'd0, 8'd0);
         for (int r = 0; r < 10; r++) begin
            if (tbl[r].k == k) begin
               chk("tbl_slot", slot, tbl[r].sl);
               chk("tbl_zero", zero, tbl[r].z);
               chk("tbl_group", group, tbl[r].g);
               chk("tbl_sub", sub, tbl[r].sb);
               chk("tbl_adv", slot_adv, tbl[r].adv);
            end
         end
         if (k < 72 && slot_adv) adv_cnt++;
         edge_step();
      end
      chk("adv_pulses_per_frame", adv_cnt, 18);

      // single write to slot 5 issued at slot 2
      do_reset();
      run_to_slot(2);
      cyc(1'b1, 1'b1, 5'd5, 8'hA5);
      got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
         cyc(1'b1, 1'b0, 5'd0, 8'd0);
         if (upd_en) begin
            got = 1;
            chk("a5_data", upd_data, 8'hA5);
            chk("a5_slot", slot, 5);
         end
      end
      chk("a5_seen", got, 1);
      ups = 0;
      for (int k = 0; k < 80; k++) begin
         cyc(1'b1, 1'b0, 5'd0, 8'd0);
         if (upd_en) ups++;
      end
      chk("a5_single_pulse", ups, 0);
      chk("a5_queue_empty", wr_ready, 1);

      // out-of-range slot is dropped and flagged
      do_reset();
      drive_mid(1'b1, 1'b1, 5'd20, 8'h3C);
      chk("bad_ready", wr_ready, 1);
      edge_step();
      ups = 0;
      for (int k = 0; k < 80; k++) begin
         cyc(1'b1, 1'b0, 5'd0, 8'd0);
         if (upd_en) ups++;
      end
      chk("bad_no_upd", ups, 0);
      chk("bad_err_sticky", err, 1);
      do_reset();
      chk("bad_err_cleared", err, 0);

      // full queue stalls the next write until the head pops
      do_reset();
      run_to_slot(4);
      cyc(1'b1, 1'b1, 5'd9, 8'h11);
`ifdef JTOPL_SCHED_FIFO2_EN
      cyc(1'b1, 1'b1, 5'd3, 8'h22);
`endif
      got = 0; n = 0;
      for (int k = 0; k < 200 && !got; k++) begin
         drive_mid(1'b1, 1'b1, 5'd7, 8'h33);
         if (wr_ready) begin
            got = 1;
            chk("stall_release_upd_en", upd_en, 1);
            chk("stall_release_data", upd_data, 8'h11);
            chk("stall_release_slot", slot, 9);
         end else n++;
         edge_step();
      end
      chk("stall_accepted", got, 1);
      chk("stall_seen", n > 0, 1);
`ifdef JTOPL_SCHED_FIFO2_EN
      ups = 0;
      for (int k = 0; k < 200 && ups < 2; k++) begin
         cyc(1'b1, 1'b0, 5'd0, 8'd0);
         if (upd_en) begin
            ups++;
            chk("fifo2_order_data", upd_data, (ups == 1) ? 8'h22 : 8'h33);
            chk("fifo2_order_slot", slot, (ups == 1) ? 3 : 7);
         end
      end
      chk("fifo2_both_applied", ups, 2);
`endif

      // reset with a write queued for slot 10
      do_reset();
      run_to_slot(3);
      cyc(1'b1, 1'b1, 5'd10, 8'h5A);
      cyc(1'b1, 1'b0, 5'd0, 8'd0);
      rst_n = 1'b0;
      model_reset();
      drive_mid(1'b1, 1'b0, 5'd0, 8'd0);
      chk("rst_slot", slot, 0);
      chk("rst_zero", zero, 1);
      chk("rst_adv", slot_adv, 0);
      chk("rst_ready", wr_ready, 1);
      chk("rst_upd_data", upd_data, 0);
      edge_step();
      rst_n = 1'b1;
      ups = 0; first_adv = -1;
      for (int k = 0; k < 80; k++) begin
         drive_mid(1'b1, 1'b0, 5'd0, 8'd0);
         if (slot_adv && first_adv < 0) first_adv = k;
         edge_step();
         if (upd_en) ups++;
      end
      chk("rst_drop_no_upd", ups, 0);
      chk("rst_first_adv", first_adv, DIV - 1);

      // randomized traffic including out-of-range slots and occasional resets
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         else cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 19)), 8'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
